// File: rtl/mul16_seq.sv
// Sequential signed multiplier: radix-2 shift-add on operand magnitudes, sign applied in a final
// fix-up cycle. Start/done handshake; 17-cycle latency, 18-cycle minimum issue interval.
module mul16_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             ov
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam int unsigned AccW = 2 * WIDTH;

   // Largest magnitudes representable as positive / negative WIDTH-bit signed results
   localparam logic [AccW-1:0] PosMax = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic [AccW-1:0] NegMax = {{WIDTH{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e            state_q, state_d;
   logic              sign_q;
   logic [WIDTH-1:0]  ma_q, mb_q;
   logic [AccW-1:0]   acc_q;
   logic [CntW-1:0]   cnt_q;
   logic [WIDTH-1:0]  out_q;
   logic              ov_q;
   logic              done_q;

   logic [WIDTH-1:0]  abs_a, abs_b;
   logic [AccW-1:0]   addend;
   logic [AccW-1:0]   prod;
   logic              ov_d;

   // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is still correct as an unsigned magnitude
   assign abs_a  = a[WIDTH-1] ? -a : a;
   assign abs_b  = b[WIDTH-1] ? -b : b;
   assign addend = {{WIDTH{1'b0}}, ma_q} << cnt_q;
   assign prod   = sign_q ? -acc_q : acc_q;
   assign ov_d   = sign_q ? (acc_q > NegMax) : (acc_q > PosMax);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StRun;
         StRun:   if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
         StFix:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q != StIdle);
      done = done_q;
      out  = out_q;
      ov   = ov_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
         ma_q   <= '0;
         mb_q   <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         out_q  <= '0;
         ov_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                  ma_q   <= abs_a;
                  mb_q   <= abs_b;
                  acc_q  <= '0;
                  cnt_q  <= '0;
               end
            end
            StRun: begin
               if (mb_q[0]) acc_q <= acc_q + addend;
               mb_q  <= mb_q >> 1;
               cnt_q <= cnt_q + CntW'(1);
            end
            StFix: begin
               out_q  <= prod[WIDTH-1:0];
               ov_q   <= ov_d;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: an abstract product/latency model checked every cycle, plus
// literal expectations per vector that pin both the DUT and the model.
module tb_mul16_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] a, b;
   logic        busy, done, ov;
   logic [15:0] out;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   mul16_seq #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .out   (out),
      .ov    (ov)
   );

   always #5 clk = ~clk;

   // Model: full signed product, result appears 17 edges after acceptance
   int                 m_rem;
   logic signed [31:0] m_p;
   logic [15:0]        e_out;
   logic               e_ov, e_done;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_rem  <= 0;
         e_out  <= '0;
         e_ov   <= 1'b0;
         e_done <= 1'b0;
      end else begin
         e_done <= 1'b0;
         if (m_rem == 0) begin
            if (start) begin
               m_rem <= 17;
               m_p   <= $signed(a) * $signed(b);
            end
         end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               e_out  <= m_p[15:0];
               e_ov   <= (m_p > 32767) || (m_p < -32768);
               e_done <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_busy", 32'(busy), 32'(m_rem != 0));
         chk("cyc_done", 32'(done), 32'(e_done));
         chk("cyc_out",  32'(out),  32'(e_out));
         chk("cyc_ov",   32'(ov),   32'(e_ov));
      end
   end

   task automatic start_op(input logic [15:0] av, input logic [15:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns negedges elapsed until done is seen (or the bound expires)
   task automatic wait_done(input int maxc, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done && cyc < maxc);
      chk("done_seen", 32'(done), 32'd1);
   endtask

   task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] eo, input logic eov);
      int c;
      start_op(av, bv);
      chk({name, "_busy"}, 32'(busy), 32'd1);
      wait_done(40, c);
      chk({name, "_lat"},   32'(c),     32'd17);
      chk({name, "_out"},   32'(out),   32'(eo));
      chk({name, "_ov"},    32'(ov),    32'(eov));
      chk({name, "_model"}, 32'(e_out), 32'(eo));
   endtask

   initial begin
      int c;
      int seen;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out",  32'(out),  32'd0);
      chk("rst_ov",   32'(ov),   32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst_n = 1'b1;

      run_op("3x5", 16'd3, 16'd5, 16'h000F, 1'b0);
      @(negedge clk);
      chk("3x5_hold_done", 32'(done), 32'd0);
      chk("3x5_hold_out",  32'(out),  32'h000F);

      run_op("m4x7",    16'hFFFC, 16'd7,    16'hFFE4, 1'b0);
      run_op("0xm5",    16'd0,    16'hFFFB, 16'h0000, 1'b0);
      run_op("256x128", 16'd256,  16'd128,  16'h8000, 1'b1);
      run_op("m256x128",16'hFF00, 16'd128,  16'h8000, 1'b0);
      run_op("minxm1",  16'h8000, 16'hFFFF, 16'h8000, 1'b1);
      run_op("maxsq",   16'h7FFF, 16'h7FFF, 16'h0001, 1'b1);

      // Start while busy is ignored
      start_op(16'd3, 16'd5);
      repeat (4) @(negedge clk);
      a     = 16'd9;
      b     = 16'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(40, c);
      chk("ign_lat", 32'(c),   32'd12);
      chk("ign_out", 32'(out), 32'h000F);

      // Start in the done cycle is accepted
      a     = 16'd2;
      b     = 16'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(40, c);
      chk("b2b_gap", 32'(c + 1), 32'd18);
      chk("b2b_out", 32'(out),   32'h0004);

      // Reset mid-op at T+8
      start_op(16'd100, 16'd100);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_out",  32'(out),  32'd0);
      chk("mrst_ov",   32'(ov),   32'd0);
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("mrst_nodone", 32'(seen), 32'd0);
      run_op("6x7", 16'd6, 16'd7, 16'h002A, 1'b0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mul16_seq.md
# mul16_seq

Sequential 16×16 signed two's-complement multiplier producing a 16-bit result and a signed-overflow flag. It is the multiply unit of the project1 ALU and sits directly upstream of the 4:1 result selector, driving that selector's slot 2 (`out2`/`ov2`). It trades latency for area with a radix-2 shift-add datapath, and uses a start/done handshake so the controller knows when slot 2 is valid.

## Interface
Parameters:
- `WIDTH`, default 16. Operand and result width. Only 16 is verified.

Ports:
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst_n`: input, 1 bit. Synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`: input, 1 bit. Request a multiply. Accepted only in IDLE.
- `a`: input, 16 bits. Signed multiplicand, sampled on the accepting edge.
- `b`: input, 16 bits. Signed multiplier, sampled on the accepting edge.
- `busy`: output, 1 bit. High while a multiply is in progress (state is not IDLE).
- `done`: output, 1 bit. One-cycle pulse; `out` and `ov` are updated in the same cycle.
- `out`: output, 16 bits. Low 16 bits of the signed 32-bit product. Feeds selector `out2`.
- `ov`: output, 1 bit. Signed overflow: the product is not representable in 16-bit signed. Feeds selector `ov2`.

## Operation
States:
- IDLE → RUN on `start`=1.
- RUN stays in RUN for 16 iterations, then → FIX.
- FIX → IDLE unconditionally.

On accept (IDLE, `start`=1):
- Latch `sign = a[15] ^ b[15]`.
- Latch `ma = |a|` and `mb = |b|` as 16-bit unsigned magnitudes (|−32768| = 0x8000, representable unsigned).
- Clear the 32-bit accumulator.
- Set `cnt = 0`.

Each RUN cycle:
- If `mb[0]`, add `ma` shifted left by `cnt` into the accumulator.
- Shift `mb` right by 1.
- `cnt` increments. When `cnt` = 15 the next state is FIX.

FIX cycle:
- `p = sign ? −acc : acc`, a 32-bit two's-complement value.
- `out <= p[15:0]`.
- `ov <= 1` iff `p` is outside [−32768, 32767]. Equivalently: for a positive result, `acc > 32767`; for a negative result, `acc > 32768`. A zero product always gives `ov = 0`, whatever `sign` is.
- `done <= 1`.

Output holding and handshake rules:
- `out` and `ov` hold their last result until the next FIX. They do not change on accept or during RUN.
- `start` while `busy` is ignored, and operand changes during RUN have no effect.
- `start` in the cycle `done` is high is accepted, because the state is IDLE. Back-to-back operation is supported.

Reset:
- `rst_n` = 0 at any edge forces IDLE and sets `out = 0`, `ov = 0`, `done = 0`, `busy = 0`, `cnt = 0`, and clears the accumulator.
- Reset mid-RUN abandons the operation; no `done` is produced.
- Reset takes priority over `start`.

## Timing
- `start` is sampled at edge T.
- `busy` is high from after edge T until edge T+17.
- RUN iterations occur at edges T+1 … T+16.
- FIX occurs at edge T+17: `out`, `ov` and `done` update there, so latency is 17 cycles.
- `done` is high for exactly the one cycle after edge T+17 and clears at T+18 unless a new operation completes.
- The earliest next accept is edge T+18, giving a minimum issue interval of 18 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then `a`=3, `b`=5, pulse `start`: `busy`=1 for 17 cycles, `done` pulses once at T+17, `out`=0x000F, `ov`=0. `out` stays 0x000F after `done` falls.
- `a`=−4 (0xFFFC), `b`=7 → `out`=0xFFE4 (−28), `ov`=0. Also `a`=0, `b`=−5 → `out`=0x0000, `ov`=0.
- Boundary cases:
  - `a`=256, `b`=128 → `out`=0x8000, `ov`=1.
  - `a`=−256, `b`=128 → `out`=0x8000, `ov`=0.
  - `a`=0x8000, `b`=0xFFFF (−32768 × −1) → `out`=0x8000, `ov`=1.
  - `a`=0x7FFF, `b`=0x7FFF → `out`=0x0001, `ov`=1.
- Handshake:
  - Start 3×5, pulse `start` again with 9×9 at T+5: it is ignored, and the result is 0x000F.
  - Assert `start` with 2×2 in the `done` cycle: accepted, `done` again 18 cycles after the first `done`, `out`=0x0004.
- Reset mid-op: start 100×100, drive `rst_n`=0 at T+8 for one edge. Required: `busy`=0, `out`=0, `ov`=0, and no `done` pulse. A following 6×7 gives `out`=0x002A.
